// File: rtl/car_wipe_acc.sv
// ---------------------------------------------------------------------------
// car_wipe_acc
//
// Carrier wipe-off and integrate-and-dump stage that sits directly behind the
// carrier NCO. Each qualified IF sample is multiplied by the NCO cosine and
// sine, the I/Q products are summed over a programmable number of samples, and
// every integration result is offered to the tracking-loop discriminator on a
// valid/ready port. Sums saturate instead of wrapping, and a result that is
// overwritten before being taken is flagged.
//
// Pipeline:
//   stage 1  : capture sample, cos, sin               (s1_*)
//   stage 2  : full-precision signed products         (p_*)
//   acc stage: saturating accumulate, count, dump     (acc_*, cnt, tx_*)
// A sample captured at edge n is accumulated (and, if it is the Nth, dumped)
// at edge n+2. One sample per clock is sustained with no bubbles.
//
// Parameters:
//   IN_W   width of IF sample and carrier inputs (signed)
//   ACC_W  accumulator and output width (signed), must be >= 2*IN_W
//   CNT_W  width of the integration length and sample counter
//
// Ports:
//   rx_clk        sole clock, rising edge
//   rx_rst        asynchronous active-high reset
//   rx_if_data    signed IF sample
//   rx_if_valid   qualifies rx_if_data / rx_car_cos / rx_car_sin
//   rx_car_cos    signed NCO cosine, time-aligned with rx_if_data
//   rx_car_sin    signed NCO sine, time-aligned with rx_if_data
//   rx_int_len    samples per integration (N); 0 disables integration
//   rx_restart    synchronous flush of pipeline, sums, counter, output, flags
//   rx_acc_ready  consumer ready
//   tx_acc_i      integrated in-phase sum
//   tx_acc_q      integrated quadrature sum
//   tx_acc_valid  tx_acc_i / tx_acc_q hold an untransferred result
//   tx_overrun    sticky: an untransferred result was overwritten
//   tx_sat        sticky: an accumulation clamped
// ---------------------------------------------------------------------------
module car_wipe_acc #(
  parameter int IN_W  = 8,
  parameter int ACC_W = 32,
  parameter int CNT_W = 16
) (
  input  logic                    rx_clk,
  input  logic                    rx_rst,
  input  logic signed [IN_W-1:0]  rx_if_data,
  input  logic                    rx_if_valid,
  input  logic signed [IN_W-1:0]  rx_car_cos,
  input  logic signed [IN_W-1:0]  rx_car_sin,
  input  logic        [CNT_W-1:0] rx_int_len,
  input  logic                    rx_restart,
  input  logic                    rx_acc_ready,
  output logic signed [ACC_W-1:0] tx_acc_i,
  output logic signed [ACC_W-1:0] tx_acc_q,
  output logic                    tx_acc_valid,
  output logic                    tx_overrun,
  output logic                    tx_sat
);

  localparam int PROD_W = 2 * IN_W;

  // -------------------------------------------------------------------------
  // Stage 1: sample capture
  // -------------------------------------------------------------------------
  logic                   s1_valid;
  logic signed [IN_W-1:0] s1_if;
  logic signed [IN_W-1:0] s1_cos;
  logic signed [IN_W-1:0] s1_sin;

  // NOTE: every register in this file is updated with non-blocking (<=)
  // assignments so all flops sample their inputs from the same pre-edge state;
  // blocking assignments here would let later statements see already-updated
  // values and silently collapse pipeline stages.
  // NOTE: the data registers are reset along with the valids even though the
  // valids alone gate their use; it keeps outputs and simulation free of X and
  // costs nothing on flop-based storage (this is not a memory array).
  always_ff @(posedge rx_clk or posedge rx_rst) begin
    if (rx_rst) begin
      s1_valid <= 1'b0;
      s1_if    <= '0;
      s1_cos   <= '0;
      s1_sin   <= '0;
    end else if (rx_restart) begin
      // A sample presented together with restart is discarded.
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= rx_if_valid;
      if (rx_if_valid) begin
        s1_if  <= rx_if_data;
        s1_cos <= rx_car_cos;
        s1_sin <= rx_car_sin;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Stage 2: carrier wipe-off products
  // -------------------------------------------------------------------------
  // Operands are sign-extended to the product width first; the low PROD_W
  // bits of the product of two sign-extended values are the exact signed
  // product, so no signedness rules of the multiply operator are relied on.
  logic [PROD_W-1:0] if_x;
  logic [PROD_W-1:0] cos_x;
  logic [PROD_W-1:0] sin_x;
  logic [PROD_W-1:0] prod_i;
  logic [PROD_W-1:0] prod_q;

  assign if_x   = {{IN_W{s1_if[IN_W-1]}},  s1_if};
  assign cos_x  = {{IN_W{s1_cos[IN_W-1]}}, s1_cos};
  assign sin_x  = {{IN_W{s1_sin[IN_W-1]}}, s1_sin};
  assign prod_i = if_x * cos_x;
  assign prod_q = if_x * sin_x;

  logic                    p_valid;
  logic signed [ACC_W-1:0] p_i;
  logic signed [ACC_W-1:0] p_q;

  always_ff @(posedge rx_clk or posedge rx_rst) begin
    if (rx_rst) begin
      p_valid <= 1'b0;
      p_i     <= '0;
      p_q     <= '0;
    end else if (rx_restart) begin
      p_valid <= 1'b0;
    end else begin
      p_valid <= s1_valid;
      if (s1_valid) begin
        p_i <= {{(ACC_W-PROD_W){prod_i[PROD_W-1]}}, prod_i};
        p_q <= {{(ACC_W-PROD_W){prod_q[PROD_W-1]}}, prod_q};
      end
    end
  end

  // -------------------------------------------------------------------------
  // Accumulate stage: saturating add, sample count, dump decision
  // -------------------------------------------------------------------------
  logic signed [ACC_W-1:0] acc_i;
  logic signed [ACC_W-1:0] acc_q;
  logic        [CNT_W-1:0] cnt;
  logic        [CNT_W-1:0] n_lat;

  // One guard bit above the accumulator: overflow is visible as the two top
  // bits of the wide sum disagreeing.
  logic [ACC_W:0]     sum_i_w;
  logic [ACC_W:0]     sum_q_w;
  logic [ACC_W-1:0]   sum_i;
  logic [ACC_W-1:0]   sum_q;
  logic               clip_i;
  logic               clip_q;
  logic [CNT_W-1:0]   cnt_inc;
  logic               acc_en;
  logic               dump;

  function automatic logic [ACC_W-1:0] clamp(input logic [ACC_W:0] w);
    logic [ACC_W-1:0] r;
    r = w[ACC_W-1:0];
    if (w[ACC_W] != w[ACC_W-1]) begin
      // Sign of the wide sum tells which rail was crossed.
      r = w[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end
    return r;
  endfunction

  // NOTE: each always_comb output is given a value on every path (defaults
  // first, then overrides); a path that leaves one unassigned would infer a
  // latch.
  always_comb begin
    sum_i_w = {acc_i[ACC_W-1], acc_i} + {p_i[ACC_W-1], p_i};
    sum_q_w = {acc_q[ACC_W-1], acc_q} + {p_q[ACC_W-1], p_q};
    sum_i   = clamp(sum_i_w);
    sum_q   = clamp(sum_q_w);
    clip_i  = sum_i_w[ACC_W] ^ sum_i_w[ACC_W-1];
    clip_q  = sum_q_w[ACC_W] ^ sum_q_w[ACC_W-1];
    cnt_inc = cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    // N = 0 disables integration: products are dropped and nothing counts.
    acc_en  = p_valid && (n_lat != '0);
    dump    = acc_en && (cnt_inc == n_lat);
  end

  always_ff @(posedge rx_clk or posedge rx_rst) begin
    if (rx_rst) begin
      acc_i        <= '0;
      acc_q        <= '0;
      cnt          <= '0;
      n_lat        <= '0;
      tx_acc_i     <= '0;
      tx_acc_q     <= '0;
      tx_acc_valid <= 1'b0;
      tx_overrun   <= 1'b0;
      tx_sat       <= 1'b0;
    end else if (rx_restart) begin
      // Restart overrides everything else on this edge. n_lat is left alone:
      // cnt is now 0, so the next edge re-latches it from rx_int_len.
      acc_i        <= '0;
      acc_q        <= '0;
      cnt          <= '0;
      tx_acc_valid <= 1'b0;
      tx_overrun   <= 1'b0;
      tx_sat       <= 1'b0;
    end else begin
      // The length only follows rx_int_len between integrations, so a change
      // never truncates or stretches the integration in progress.
      if (cnt == '0) begin
        n_lat <= rx_int_len;
      end

      if (acc_en) begin
        if (clip_i || clip_q) begin
          tx_sat <= 1'b1;
        end
        if (dump) begin
          acc_i <= '0;
          acc_q <= '0;
          cnt   <= '0;
        end else begin
          acc_i <= sum_i;
          acc_q <= sum_q;
          cnt   <= cnt_inc;
        end
      end

      // Output port. A dump always loads and asserts valid; only a dump onto
      // a result the consumer is not taking this edge counts as an overrun.
      if (dump) begin
        tx_acc_i     <= sum_i;
        tx_acc_q     <= sum_q;
        tx_acc_valid <= 1'b1;
        if (tx_acc_valid && !rx_acc_ready) begin
          tx_overrun <= 1'b1;
        end
      end else if (tx_acc_valid && rx_acc_ready) begin
        tx_acc_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_car_wipe_acc.sv
// ---------------------------------------------------------------------------
// tb_car_wipe_acc
//
// Bench for car_wipe_acc, built with ACC_W = 20 so saturation is reachable
// with short integrations. A reference model steps once per rising edge,
// working from the block's rules with integer arithmetic: a two-entry delay
// line of products, a running sum clamped to the ACC_W range, a sample count
// against the integration length, and a one-entry result slot with
// valid/ready and sticky flags. All outputs are compared 1 time unit after
// every edge, and directed sections add checks against hand-computed
// constants.
// ---------------------------------------------------------------------------
module tb_car_wipe_acc;

  localparam int IN_W  = 8;
  localparam int ACC_W = 20;
  localparam int CNT_W = 16;

  logic                    rx_clk = 1'b0;
  logic                    rx_rst;
  logic signed [IN_W-1:0]  rx_if_data;
  logic                    rx_if_valid;
  logic signed [IN_W-1:0]  rx_car_cos;
  logic signed [IN_W-1:0]  rx_car_sin;
  logic        [CNT_W-1:0] rx_int_len;
  logic                    rx_restart;
  logic                    rx_acc_ready;
  logic signed [ACC_W-1:0] tx_acc_i;
  logic signed [ACC_W-1:0] tx_acc_q;
  logic                    tx_acc_valid;
  logic                    tx_overrun;
  logic                    tx_sat;

  car_wipe_acc #(.IN_W(IN_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .rx_clk       (rx_clk),
    .rx_rst       (rx_rst),
    .rx_if_data   (rx_if_data),
    .rx_if_valid  (rx_if_valid),
    .rx_car_cos   (rx_car_cos),
    .rx_car_sin   (rx_car_sin),
    .rx_int_len   (rx_int_len),
    .rx_restart   (rx_restart),
    .rx_acc_ready (rx_acc_ready),
    .tx_acc_i     (tx_acc_i),
    .tx_acc_q     (tx_acc_q),
    .tx_acc_valid (tx_acc_valid),
    .tx_overrun   (tx_overrun),
    .tx_sat       (tx_sat)
  );

  always #5 rx_clk = ~rx_clk;

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- reference model ----------------
  typedef struct {
    bit     v;
    longint pi;
    longint pq;
  } prod_t;

  prod_t  dly[2];      // dly[0]: captured last edge, dly[1]: reaches the sum now
  longint m_sum_i, m_sum_q;
  int     m_count;
  int     m_len;       // length in force for the current integration
  longint m_out_i, m_out_q;
  bit     m_valid, m_ovr, m_sat;

  function automatic longint lim(input longint v, inout bit clipped);
    longint hi, lo;
    hi = (longint'(1) <<< (ACC_W - 1)) - 1;
    lo = -(longint'(1) <<< (ACC_W - 1));
    if (v > hi) begin clipped = 1'b1; return hi; end
    if (v < lo) begin clipped = 1'b1; return lo; end
    return v;
  endfunction

  function automatic void mdl_reset();
    dly[0] = '{0, 0, 0};
    dly[1] = '{0, 0, 0};
    m_sum_i = 0; m_sum_q = 0; m_count = 0; m_len = 0;
    m_out_i = 0; m_out_q = 0;
    m_valid = 0; m_ovr = 0; m_sat = 0;
  endfunction

  // One rising edge, using the inputs as presented before the edge.
  function automatic void mdl_edge();
    bit     dumped, clipped;
    longint ni, nq;
    int     next_len;
    if (rx_restart) begin
      dly[0].v = 0; dly[1].v = 0;
      m_sum_i = 0; m_sum_q = 0; m_count = 0;
      m_valid = 0; m_ovr = 0; m_sat = 0;
      return;
    end
    dumped = 0; clipped = 0; ni = 0; nq = 0;
    next_len = (m_count == 0) ? int'(rx_int_len) : m_len;
    if (dly[1].v && m_len != 0) begin
      ni = lim(m_sum_i + dly[1].pi, clipped);
      nq = lim(m_sum_q + dly[1].pq, clipped);
      if (clipped) m_sat = 1;
      m_count++;
      if (m_count == m_len) begin
        dumped = 1; m_sum_i = 0; m_sum_q = 0; m_count = 0;
      end else begin
        m_sum_i = ni; m_sum_q = nq;
      end
    end
    if (dumped) begin
      if (m_valid && !rx_acc_ready) m_ovr = 1;
      m_out_i = ni; m_out_q = nq; m_valid = 1;
    end else if (m_valid && rx_acc_ready) begin
      m_valid = 0;
    end
    m_len = next_len;
    dly[1] = dly[0];
    dly[0].v = rx_if_valid;
    dly[0].pi = longint'(rx_if_data) * longint'(rx_car_cos);
    dly[0].pq = longint'(rx_if_data) * longint'(rx_car_sin);
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cmp_all();
    check("acc_valid", tx_acc_valid, m_valid);
    check("acc_i", tx_acc_i, m_out_i);
    check("acc_q", tx_acc_q, m_out_q);
    check("overrun", tx_overrun, m_ovr);
    check("sat", tx_sat, m_sat);
  endtask

  task automatic step();
    @(posedge rx_clk);
    mdl_edge();
    #1;
    cmp_all();
  endtask

  task automatic drive(input bit v, input int d, input int c, input int s);
    rx_if_valid = v;
    rx_if_data  = IN_W'(d);
    rx_car_cos  = IN_W'(c);
    rx_car_sin  = IN_W'(s);
  endtask

  task automatic restart();
    rx_restart  = 1'b1;
    rx_if_valid = 1'b0;
    step();
    rx_restart  = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rx_rst = 1'b1;
    rx_restart = 1'b0;
    rx_acc_ready = 1'b0;
    rx_int_len = '0;
    drive(0, 0, 0, 0);
    mdl_reset();
    #12;
    check("rst_valid", tx_acc_valid, 0);
    check("rst_i", tx_acc_i, 0);
    check("rst_q", tx_acc_q, 0);
    check("rst_flags", {tx_overrun, tx_sat}, 0);
    rx_rst = 1'b0;

    // Basic sums: N=4, 10*20=200 and 10*-5=-50 per sample.
    rx_int_len = 16'd4; rx_acc_ready = 1'b1;
    drive(1, 10, 20, -5);
    for (int k = 1; k <= 5; k++) begin
      step();
      check("basic_early", tx_acc_valid, 0);
    end
    step();   // edge 6: two after the 4th capture
    check("basic_valid", tx_acc_valid, 1);
    check("basic_i", tx_acc_i, 800);
    check("basic_q", tx_acc_q, -200);
    for (int k = 7; k <= 9; k++) begin
      step();
      check("basic_gap", tx_acc_valid, 0);
    end
    step();
    check("basic_valid2", tx_acc_valid, 1);
    check("basic_i2", tx_acc_i, 800);
    drive(0, 0, 0, 0);
    repeat (3) step();

    // Back-pressure, ready low through the second dump: overrun.
    restart();
    rx_int_len = 16'd2; rx_acc_ready = 1'b0;
    drive(1, 1, 1, 1);
    repeat (2) step();
    drive(1, 2, 1, 1);
    step();
    check("bp_none", tx_acc_valid, 0);
    step();
    check("bp_first", tx_acc_i, 2);
    check("bp_first_v", tx_acc_valid, 1);
    step();
    check("bp_hold", tx_acc_i, 2);
    check("bp_hold_v", tx_acc_valid, 1);
    step();
    check("bp_second", tx_acc_i, 4);
    check("bp_ovr", tx_overrun, 1);
    rx_acc_ready = 1'b1; drive(0, 0, 0, 0);
    repeat (3) step();

    // Same, but ready rises for the second dump edge: no overrun.
    restart();
    rx_acc_ready = 1'b0;
    drive(1, 1, 1, 1);
    repeat (2) step();
    drive(1, 2, 1, 1);
    repeat (3) step();
    rx_acc_ready = 1'b1;
    step();
    check("bpr_ovr", tx_overrun, 0);
    check("bpr_valid", tx_acc_valid, 1);
    check("bpr_i", tx_acc_i, 4);
    drive(0, 0, 0, 0);
    repeat (3) step();

    // Saturation high then low, N=40.
    restart();
    rx_int_len = 16'd40;
    drive(1, -128, -128, 0);
    for (int k = 1; k <= 41; k++) begin
      step();
      if (k == 40) drive(0, 0, 0, 0);
    end
    step();
    check("sat_hi_i", tx_acc_i, 524287);
    check("sat_hi_q", tx_acc_q, 0);
    check("sat_hi_flag", tx_sat, 1);
    drive(1, -128, 127, 0);
    for (int k = 1; k <= 41; k++) begin
      step();
      if (k == 40) drive(0, 0, 0, 0);
    end
    step();
    check("sat_lo_i", tx_acc_i, -524288);
    check("sat_lo_valid", tx_acc_valid, 1);

    // Restart mid-integration: partial sum and flags discarded.
    rx_int_len = 16'd4;
    drive(1, 3, 1, 0);
    repeat (4) step();
    rx_restart = 1'b1;
    drive(1, 100, 1, 0);
    step();
    rx_restart = 1'b0;
    check("rs_sat", tx_sat, 0);
    check("rs_valid", tx_acc_valid, 0);
    drive(1, 5, 1, 0);
    repeat (4) step();
    drive(0, 0, 0, 0);
    step();
    step();
    check("rs_i", tx_acc_i, 20);
    check("rs_valid2", tx_acc_valid, 1);

    // Gapped input, N=3: captures at edges 1,3,5 -> dump at edge 7.
    restart();
    rx_int_len = 16'd3;
    drive(1, 1, 5, 1); step();
    drive(0, 0, 0, 0); step();
    drive(1, 2, 5, 1); step();
    drive(0, 0, 0, 0); step();
    drive(1, 3, 5, 1); step();
    drive(0, 0, 0, 0); step();
    check("gap_early", tx_acc_valid, 0);
    step();
    check("gap_valid", tx_acc_valid, 1);
    check("gap_i", tx_acc_i, 30);
    check("gap_q", tx_acc_q, 6);
    step();
    check("gap_once", tx_acc_valid, 0);

    // Length change 4 -> 2 once the integration is under way.
    restart();
    rx_int_len = 16'd4;
    drive(1, 1, 1, 1);
    repeat (4) step();
    rx_int_len = 16'd2;
    repeat (2) step();
    check("len_old_i", tx_acc_i, 4);
    step();
    step();
    check("len_new_i", tx_acc_i, 2);
    check("len_new_v", tx_acc_valid, 1);
    repeat (2) step();
    check("len_new_i2", tx_acc_i, 2);
    drive(0, 0, 0, 0);

    // N = 0: no dumps at all.
    restart();
    rx_int_len = '0;
    for (int k = 0; k < 20; k++) begin
      drive(1, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
      step();
      check("n0_valid", tx_acc_valid, 0);
    end
    drive(0, 0, 0, 0);
    repeat (3) step();

    // Randomized traffic against the model.
    for (int k = 0; k < 800; k++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 255),
            $urandom_range(0, 255), $urandom_range(0, 255));
      rx_acc_ready = 1'($urandom_range(0, 1));
      rx_restart   = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 19) == 0) begin
        case ($urandom_range(0, 5))
          0: rx_int_len = 16'd0;
          1: rx_int_len = 16'd1;
          2: rx_int_len = 16'd2;
          3: rx_int_len = 16'd3;
          4: rx_int_len = 16'd5;
          default: rx_int_len = 16'd37;
        endcase
      end
      step();
    end
    rx_restart = 1'b0;

    // Asynchronous reset mid-integration and mid-handshake.
    restart();
    rx_int_len = 16'd2; rx_acc_ready = 1'b0;
    drive(1, 7, 3, 2);
    repeat (6) step();
    check("ar_pre_valid", tx_acc_valid, 1);
    #3;
    rx_rst = 1'b1;
    mdl_reset();
    #1;
    check("ar_valid", tx_acc_valid, 0);
    check("ar_i", tx_acc_i, 0);
    check("ar_q", tx_acc_q, 0);
    check("ar_ovr", tx_overrun, 0);
    #2;
    rx_rst = 1'b0;
    rx_acc_ready = 1'b1;
    repeat (10) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/car_wipe_acc.md
# car_wipe_acc

Carrier wipe-off and integrate-and-dump stage directly downstream of the carrier NCO. Each qualified IF sample is multiplied by the NCO cosine and sine outputs. The I and Q products are accumulated over a programmable number of samples, and each integration result is presented on a valid/ready output port to the tracking-loop discriminator. The stage is pipelined (2 stages ahead of the accumulator), saturates on overflow, and flags results lost to back-pressure.

## Interface
- IN_W, 8: width of IF sample and carrier inputs, signed two's complement.
- ACC_W, 32: accumulator and output width, signed.
- CNT_W, 16: width of the integration-length input and the sample counter.

- rx_clk  in  1  sole clock, rising edge.
- rx_rst  in  1  reset, asynchronous, active-high.
- rx_if_data  in  IN_W  signed IF sample.
- rx_if_valid  in  1  sample qualifier; rx_if_data, rx_car_cos and rx_car_sin are captured together when high.
- rx_car_cos  in  IN_W  signed NCO cosine, time-aligned with rx_if_data.
- rx_car_sin  in  IN_W  signed NCO sine, time-aligned with rx_if_data.
- rx_int_len  in  CNT_W  N = samples per integration; 0 = integration disabled.
- rx_restart  in  1  synchronous flush of pipeline, accumulators, counter, output and flags.
- rx_acc_ready  in  1  consumer ready.
- tx_acc_i  out  ACC_W  integrated in-phase sum.
- tx_acc_q  out  ACC_W  integrated quadrature sum.
- tx_acc_valid  out  1  tx_acc_i and tx_acc_q hold an untransferred result.
- tx_overrun  out  1  sticky; set when an untransferred result is overwritten.
- tx_sat  out  1  sticky; set when any accumulation clamps.

## Operation
- Stage 1: on rx_if_valid, register the sample, cos and sin, and set s1_valid.
- Stage 2: compute p_i = if*cos and p_q = if*sin as full 2*IN_W signed products, sign-extended to ACC_W; the product valid follows s1_valid.
- Accumulate stage, on each product valid:
  - sum_i = acc_i + p_i and sum_q = acc_q + p_q, each clamped to [-(2^(ACC_W-1)), 2^(ACC_W-1)-1].
  - Any clamp sets tx_sat.
  - Increment cnt.
- N latch: N is latched from rx_int_len whenever cnt = 0, so a change takes effect only at an integration boundary.
- Dump: when the incremented cnt equals latched N, load the clamped sums into tx_acc_i/tx_acc_q, set tx_acc_valid, and clear acc_i, acc_q and cnt to 0. The Nth sample is part of the dumped sum; the next sample starts a fresh integration.
- N = 0: accumulators and cnt are held at 0, products are discarded, and no dumps occur. Stage 1 and stage 2 keep running.
- Handshake:
  - A transfer occurs on an edge where tx_acc_valid and rx_acc_ready are both high; tx_acc_valid then clears unless a dump happens on the same edge.
  - Outputs stay stable while valid and not ready.
- Dump while tx_acc_valid is high:
  - Without ready on that edge: overwrite the outputs, keep valid high, set tx_overrun.
  - With ready on that edge: the old result transfers, the new one loads, valid stays high, and no overrun is flagged.
- rx_restart:
  - Clears s1_valid, the product valid, acc_i, acc_q, cnt, tx_acc_valid, tx_overrun and tx_sat.
  - Re-latches N on the following edge.
  - Overrides every simultaneous event; a sample presented with rx_restart is discarded.
- Reset values: every register and output is 0, including tx_acc_i, tx_acc_q, tx_acc_valid, tx_overrun, tx_sat, cnt and latched N.

## Timing
- Capture: a sample captured at edge n reaches the accumulator at edge n+2.
- Dump latency: when that sample is the Nth, tx_acc_valid and the data update at edge n+2.
- Throughput: one sample per clock, back-to-back, with no bubbles. With rx_if_valid held high, dumps occur every N clocks.
- Pipeline gaps: when rx_if_valid is low, stage valids propagate as bubbles and cnt does not advance.
- rx_acc_ready has no combinational path to any output.
- Asynchronous rx_rst takes effect immediately, including mid-integration and mid-handshake; no partial result survives.

## Test plan
- Basic sums, N=4, rx_acc_ready=1, if=10, cos=20, sin=-5 every clock → tx_acc_i=800, tx_acc_q=-200; tx_acc_valid pulses 1 clock every 4 clocks; the first pulse comes at the edge 2 after the 4th capture.
- Back-pressure, N=2, rx_acc_ready=0, constant if=1, cos=1 → the first result is held until the second dump; then the outputs update and tx_overrun=1. Asserting ready on the dump edge instead leaves tx_overrun=0.
- Saturation, ACC_W=20, N=40, if=-128, cos=-128 → tx_acc_i=524287 and tx_sat=1. With if=-128, cos=127 → tx_acc_i=-524288 (-16256*40 lies below the minimum).
- Gapped input, N=3, rx_if_valid toggling 1,0,1,0,1 → a single dump containing exactly 3 products, at the edge 2 after the third valid capture.
- Length change and restart:
  - Change rx_int_len from 4 to 2 mid-integration → the current dump still covers 4 samples; subsequent dumps cover 2.
  - rx_restart mid-integration → the partial sum is discarded, the next dump covers N fresh samples, and the flags are cleared.
- Reset, N=0: N=0 yields no dumps. Asynchronous rx_rst pulsed between clock edges drives all outputs to 0 immediately.
